// File: rtl/sinc3_sigma_delta_decimator_if.sv
// Bitstream-in / PCM-out bundle of the sinc^3 decimator.
// bit_valid qualifies bit_in for one bit per high cycle; dout_valid pulses when dout
// and dout_sat are new. There is no ready: the consumer must take dout that cycle.
interface sinc3_sigma_delta_decimator_if;
    logic               bit_in;
    logic               bit_valid;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_sat;
    logic [1:0]         warm_state;

    modport master (
        output bit_in, bit_valid,
        input  dout, dout_valid, dout_sat, warm_state
    );

    modport slave (
        input  bit_in, bit_valid,
        output dout, dout_valid, dout_sat, warm_state
    );
endinterface

// File: rtl/sinc3_sigma_delta_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, saturated 16-bit PCM out.
// warm_state on the interface exposes the warm-up FSM for observation.
module sinc3_sigma_delta_decimator #(
    parameter int DECIM = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sinc3_sigma_delta_decimator_if.slave  sd
);
    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 3 * LOG2D + 2;
    localparam int SHIFT = 3 * LOG2D - 15;

    localparam logic signed [W-1:0] S_MAX = W'(32767);
    localparam logic signed [W-1:0] S_MIN = W'(-32768);

    generate
        if ((DECIM < 32) || (DECIM > 1024) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
            $error("DECIM must be a power of 2 in 32..1024");
        end
    endgenerate

    typedef enum logic [1:0] {WARM0, WARM1, WARM2, RUN} warm_t;

    warm_t                state, state_next;
    logic signed [W-1:0]  i1, i2, i3;
    logic signed [W-1:0]  i1_next, i2_next, i3_next;
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  d1, d2, d3;
    logic signed [W-1:0]  c1, c2, c3;
    logic signed [W-1:0]  c3_q;
    logic signed [W-1:0]  s;
    logic [LOG2D-1:0]     cnt;
    logic                 strobe;
    logic                 c3_valid;

    // Integrators cascade combinationally so one accepted bit updates all three.
    assign x       = sd.bit_in ? W'(1) : {W{1'b1}};
    assign i1_next = i1 + x;
    assign i2_next = i2 + i1_next;
    assign i3_next = i3 + i2_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1     <= '0;
            i2     <= '0;
            i3     <= '0;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= sd.bit_valid && (cnt == LOG2D'(DECIM - 1));
            if (sd.bit_valid) begin
                i1  <= i1_next;
                i2  <= i2_next;
                i3  <= i3_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Combs run at the output rate; equal width makes integrator wrap harmless.
    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            c3_q     <= '0;
            c3_valid <= 1'b0;
        end else begin
            c3_valid <= strobe && (state == RUN);
            if (strobe) begin
                d1   <= i3;
                d2   <= c1;
                d3   <= c2;
                c3_q <= c3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WARM0;
        else        state <= state_next;
    end

    // The first three strobes only prime the comb delays.
    always_comb begin
        state_next = state;
        if (strobe) begin
            case (state)
                WARM0:   state_next = WARM1;
                WARM1:   state_next = WARM2;
                WARM2:   state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    assign s = c3_q >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd.dout       <= '0;
            sd.dout_valid <= 1'b0;
            sd.dout_sat   <= 1'b0;
        end else begin
            sd.dout_valid <= c3_valid;
            if (c3_valid) begin
                if (s > S_MAX) begin
                    sd.dout     <= 16'sd32767;
                    sd.dout_sat <= 1'b1;
                end else if (s < S_MIN) begin
                    sd.dout     <= -16'sd32768;
                    sd.dout_sat <= 1'b1;
                end else begin
                    sd.dout     <= s[15:0];
                    sd.dout_sat <= 1'b0;
                end
            end else begin
                sd.dout_sat <= 1'b0;
            end
        end
    end

    assign sd.warm_state = state;
endmodule

// File: tb/tb_sinc3_sigma_delta_decimator.sv
// Directed bench for the sinc^3 decimator: constant, periodic and gapped bitstreams,
// warm-up, latency and asynchronous reset behaviour.
module tb_sinc3_sigma_delta_decimator;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   bits_since_rst = 0;

    int          exp_cyc_q[$];
    int          got_cyc_q[$];
    logic [15:0] got_dout_q[$];
    logic        got_sat_q[$];

    sinc3_sigma_delta_decimator_if sd ();

    sinc3_sigma_delta_decimator #(.DECIM(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sd    (sd)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record every output pulse with the edge number that produced it
    always @(negedge clk) begin
        if (sd.dout_valid) begin
            got_cyc_q.push_back(cyc);
            got_dout_q.push_back(sd.dout);
            got_sat_q.push_back(sd.dout_sat);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (n % 2) == 0;
            3:       return (n % 4) != 3;
            default: return (n % 4) == 0;
        endcase
    endfunction

    // one cycle of input; every 64th accepted bit from the 4th block on predicts a pulse
    task automatic drive(input logic b, input logic v);
        @(negedge clk);
        sd.bit_in    = b;
        sd.bit_valid = v;
        if (v) begin
            bits_since_rst++;
            if ((bits_since_rst % 64) == 0 && bits_since_rst >= 256)
                exp_cyc_q.push_back(cyc + 3);
        end
    endtask

    task automatic run(input int mode, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            drive(pat(mode, bits_since_rst), 1'b1);
            repeat (gap) drive(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        sd.bit_in    = 1'b0;
        sd.bit_valid = 1'b0;
        #1;
        chk("rst_dout", {{16{sd.dout[15]}}, sd.dout}, 0);
        chk("rst_valid", {31'd0, sd.dout_valid}, 0);
        chk("rst_sat", {31'd0, sd.dout_sat}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bits_since_rst = 0;
        exp_cyc_q.delete();
        got_cyc_q.delete();
        got_dout_q.delete();
        got_sat_q.delete();
    endtask

    task automatic check_pulses(input string tag, input int exp_dout, input logic exp_sat);
        int n;
        logic [15:0] d;
        repeat (4) drive(1'b0, 1'b0);
        chk({tag, "_count"}, got_cyc_q.size(), exp_cyc_q.size());
        n = (got_cyc_q.size() < exp_cyc_q.size()) ? got_cyc_q.size() : exp_cyc_q.size();
        for (int i = 0; i < n; i++) begin
            d = got_dout_q.pop_front();
            chk({tag, "_cycle"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
            chk({tag, "_dout"}, {{16{d[15]}}, d}, exp_dout);
            chk({tag, "_sat"}, {31'd0, got_sat_q.pop_front()}, {31'd0, exp_sat});
        end
        exp_cyc_q.delete();
        got_cyc_q.delete();
        got_dout_q.delete();
        got_sat_q.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        sd.bit_in    = 1'b0;
        sd.bit_valid = 1'b0;
        do_reset();
        chk("rst_warm", {30'd0, sd.warm_state}, 0);

        // full-scale +1: clipped to 32767 from the 4th block on
        run(0, 384, 0);
        check_pulses("ones", 32767, 1'b1);
        chk("ones_hold", {{16{sd.dout[15]}}, sd.dout}, 32767);
        chk("ones_warm", {30'd0, sd.warm_state}, 3);

        // 100 bits into a block, then asynchronous reset; warm-up must restart
        run(0, 100, 0);
        do_reset();
        chk("rst2_warm", {30'd0, sd.warm_state}, 0);

        run(1, 384, 0);
        check_pulses("zeros", -32768, 1'b0);

        do_reset();
        run(2, 384, 0);
        check_pulses("alt", 0, 1'b0);

        do_reset();
        run(3, 320, 0);
        check_pulses("p1110", 16384, 1'b0);

        do_reset();
        run(4, 320, 0);
        check_pulses("p1000", -16384, 1'b0);

        // one bit every 3rd cycle: same values, pulses 192 clk apart
        do_reset();
        run(0, 320, 2);
        check_pulses("gap", 32767, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
